// File: rtl/btn_pkg.sv
// -----------------------------------------------------------------------------
// btn_pkg
// Shared definitions for the Basys 3 push-button conditioner and its consumers:
// button count, button index constants, one-hot command encodings and a
// lowest-set-bit helper used by the priority issue logic.
// -----------------------------------------------------------------------------
package btn_pkg;

  localparam int N_BTN = 5;

  typedef logic [N_BTN-1:0] btn_vec_t;

  // Bit index of each button (bit index = button id).
  localparam int BTN_RESET  = 0;
  localparam int BTN_NEXT   = 1;
  localparam int BTN_STAND  = 2;
  localparam int BTN_HIT    = 3;
  localparam int BTN_DOUBLE = 4;

  // One-hot commands as seen on btn_pulse by the game/display logic.
  localparam btn_vec_t CMD_RESET  = btn_vec_t'(1) << BTN_RESET;
  localparam btn_vec_t CMD_NEXT   = btn_vec_t'(1) << BTN_NEXT;
  localparam btn_vec_t CMD_STAND  = btn_vec_t'(1) << BTN_STAND;
  localparam btn_vec_t CMD_HIT    = btn_vec_t'(1) << BTN_HIT;
  localparam btn_vec_t CMD_DOUBLE = btn_vec_t'(1) << BTN_DOUBLE;

  // Isolates the lowest set bit; zero in gives zero out.
  function automatic btn_vec_t lowest_one(input btn_vec_t v);
    return v & (~v + btn_vec_t'(1));
  endfunction

endpackage

// File: rtl/btn_conditioner_if.sv
// -----------------------------------------------------------------------------
// btn_conditioner_if
// Bundles the button-side and command-side signals of the conditioner.
//   btn_raw   : raw asynchronous button levels (into the conditioner)
//   btn_level : debounced level per button
//   btn_pulse : one-cycle, one-hot (or zero) press command
//   busy      : a press is pending but not yet issued
// slave  : the conditioner itself
// master : the environment (buttons in, commands out to the game logic)
// -----------------------------------------------------------------------------
interface btn_conditioner_if;
  import btn_pkg::*;

  btn_vec_t btn_raw;
  btn_vec_t btn_level;
  btn_vec_t btn_pulse;
  logic     busy;

  modport slave (
    input  btn_raw,
    output btn_level,
    output btn_pulse,
    output busy
  );

  modport master (
    output btn_raw,
    input  btn_level,
    input  btn_pulse,
    input  busy
  );

endinterface

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// Single-bit front end: two-flop synchroniser, stability counter and the
// debounced level register.
//   clk    : system clock
//   reset  : synchronous, active-high reset
//   raw    : asynchronous button level
//   level  : debounced level (registered)
//   rise   : high in the cycle whose closing edge raises level 0->1
// -----------------------------------------------------------------------------
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;
  logic             qualify;

  // The counter only advances while s2 differs from level, and the terminal
  // count always resolves the difference, so it can never pass CNT_LAST.
  assign qualify = (s2 != level) && (cnt == CNT_LAST);

  // Lets the top register the press on the same edge that level rises.
  assign rise = qualify && s2;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, which is what makes s1 -> s2 a real two-stage chain.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      if (s2 == level) begin
        cnt <= '0;             // stable or bounced back: restart qualification
      end else if (qualify) begin
        level <= s2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/btn_conditioner.sv
// -----------------------------------------------------------------------------
// btn_conditioner
// Synchronises and debounces every push-button, records each qualified press
// as pending, and issues at most one one-hot command pulse per cycle, lowest
// button index first. Issuing the reset button flushes all other pending
// presses, including any press qualifying on that same edge.
//   clk   : system clock, all state on rising edge
//   reset : synchronous, active-high system reset
//   bus   : btn_conditioner_if.slave (btn_raw in; btn_level, btn_pulse, busy out)
// -----------------------------------------------------------------------------
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = 20
) (
  input  logic               clk,
  input  logic               reset,
  btn_conditioner_if.slave   bus
);

  btn_vec_t level;
  btn_vec_t rise;
  btn_vec_t pending;
  btn_vec_t pending_next;
  btn_vec_t issue;
  btn_vec_t pulse;
  logic     busy;

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_debounce (
      .clk   (clk),
      .reset (reset),
      .raw   (bus.btn_raw[i]),
      .level (level[i]),
      .rise  (rise[i])
    );
  end

  // NOTE: every signal written here gets a value on every path (issue first,
  // pending_next on both branches) so no latch is inferred.
  always_comb begin
    issue = lowest_one(pending);
    if (issue[BTN_RESET]) begin
      pending_next = '0;                      // flush, new presses dropped too
    end else begin
      // OR-ing rise after the clear means a same-bit re-press survives.
      pending_next = (pending & ~issue) | rise;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= '0;
      pulse   <= '0;
      busy    <= 1'b0;
    end else begin
      pending <= pending_next;
      pulse   <= issue;
      busy    <= |pending_next;
    end
  end

  assign bus.btn_level = level;
  assign bus.btn_pulse = pulse;
  assign bus.busy      = busy;

endmodule

// File: tb/tb_btn_conditioner.sv
// -----------------------------------------------------------------------------
// tb_btn_conditioner
// Directed bench for btn_conditioner with DEBOUNCE_CYCLES=4, CNT_W=3.
// Edge numbering: after btn_raw changes, the next rising edge is edge 0.
// Outputs are sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_btn_conditioner;
  import btn_pkg::*;

  logic clk;
  logic reset;

  btn_conditioner_if bus ();

  btn_conditioner #(
    .DEBOUNCE_CYCLES (4),
    .CNT_W           (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Per-scenario observation record.
  int       edge_no;
  int       watch;
  int       pulse_cnt;
  int       pulse_edge;
  int       lvl_edge;
  int       busy_cnt;
  int       onehot_bad;
  btn_vec_t pulse_or;
  btn_vec_t hist_pulse [64];
  logic     hist_busy  [64];

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_stats(input int w);
    edge_no    = 0;
    watch      = w;
    pulse_cnt  = 0;
    pulse_edge = -1;
    lvl_edge   = -1;
    busy_cnt   = 0;
    pulse_or   = '0;
    for (int i = 0; i < 64; i++) begin
      hist_pulse[i] = '0;
      hist_busy[i]  = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (bus.btn_pulse != '0) begin
      pulse_cnt++;
      pulse_edge = edge_no;
      pulse_or   = pulse_or | bus.btn_pulse;
    end
    if ($countones(bus.btn_pulse) > 1) onehot_bad++;
    if (bus.btn_level[watch] && lvl_edge < 0) lvl_edge = edge_no;
    if (bus.busy) busy_cnt++;
    if (edge_no < 64) begin
      hist_pulse[edge_no] = bus.btn_pulse;
      hist_busy[edge_no]  = bus.busy;
    end
    edge_no++;
  endtask

  task automatic release_all();
    bus.btn_raw = '0;
    repeat (8) tick();
  endtask

  initial begin
    onehot_bad  = 0;
    clear_stats(0);
    reset       = 1'b1;
    bus.btn_raw = '0;
    repeat (2) tick();
    reset = 1'b0;
    check("reset_level", int'(bus.btn_level), 0);
    check("reset_pulse", int'(bus.btn_pulse), 0);
    check("reset_busy",  int'(bus.busy), 0);

    // 1) Hit held 20 cycles: level after edge 5, single pulse after edge 6.
    clear_stats(BTN_HIT);
    bus.btn_raw = CMD_HIT;
    repeat (20) tick();
    check("hold_level_edge", lvl_edge, 5);
    check("hold_pulse_cnt",  pulse_cnt, 1);
    check("hold_pulse_edge", pulse_edge, 6);
    check("hold_pulse_val",  int'(pulse_or), int'(5'b01000));
    check("hold_level_end",  int'(bus.btn_level[BTN_HIT]), 1);
    release_all();
    check("hold_release_no_pulse", pulse_cnt, 1);
    check("hold_release_level", int'(bus.btn_level[BTN_HIT]), 0);

    // 2) Hit bounces 1,1,0,0,... for 12 edges, then stable high from edge 12.
    clear_stats(BTN_HIT);
    for (int i = 0; i < 12; i++) begin
      bus.btn_raw = ((i / 2) % 2 == 0) ? CMD_HIT : '0;
      tick();
    end
    check("bounce_level_low", lvl_edge, -1);
    bus.btn_raw = CMD_HIT;
    repeat (14) tick();
    check("bounce_level_edge", lvl_edge, 17);
    check("bounce_pulse_cnt",  pulse_cnt, 1);
    check("bounce_pulse_edge", pulse_edge, 18);
    check("bounce_pulse_val",  int'(pulse_or), int'(5'b01000));
    release_all();

    // 3) Stand high for only 3 cycles: never qualifies.
    clear_stats(BTN_STAND);
    bus.btn_raw = CMD_STAND;
    repeat (3) tick();
    bus.btn_raw = '0;
    repeat (12) tick();
    check("short_level", lvl_edge, -1);
    check("short_pulse", pulse_cnt, 0);
    check("short_busy",  busy_cnt, 0);

    // 4) Next and stand together: next first, stand on the following cycle.
    clear_stats(BTN_NEXT);
    bus.btn_raw = CMD_NEXT | CMD_STAND;
    repeat (12) tick();
    check("pair_pulse_cnt", pulse_cnt, 2);
    check("pair_pulse_e6",  int'(hist_pulse[6]), int'(5'b00010));
    check("pair_pulse_e7",  int'(hist_pulse[7]), int'(5'b00100));
    check("pair_busy_e5",   int'(hist_busy[5]), 1);
    check("pair_busy_e6",   int'(hist_busy[6]), 1);
    check("pair_busy_e7",   int'(hist_busy[7]), 0);
    check("pair_busy_cnt",  busy_cnt, 2);
    release_all();
    check("pair_release_no_pulse", pulse_cnt, 2);

    // 5) Hit and reset-button qualify together: reset issues and flushes hit.
    clear_stats(BTN_RESET);
    bus.btn_raw = CMD_HIT | CMD_RESET;
    repeat (12) tick();
    check("flush_pulse_cnt", pulse_cnt, 1);
    check("flush_pulse_e6",  int'(hist_pulse[6]), int'(5'b00001));
    check("flush_pulse_or",  int'(pulse_or), int'(5'b00001));
    check("flush_busy_cnt",  busy_cnt, 1);
    check("flush_busy_end",  int'(bus.busy), 0);
    release_all();
    check("flush_release_no_pulse", pulse_cnt, 1);

    // 6) Double held, system reset at edge 4, double still held afterwards.
    clear_stats(BTN_DOUBLE);
    bus.btn_raw = CMD_DOUBLE;
    repeat (4) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("sysrst_level", int'(bus.btn_level), 0);
    check("sysrst_pulse", int'(bus.btn_pulse), 0);
    check("sysrst_busy",  int'(bus.busy), 0);
    clear_stats(BTN_DOUBLE);
    repeat (10) tick();
    check("sysrst_level_edge", lvl_edge, 5);
    check("sysrst_pulse_cnt",  pulse_cnt, 1);
    check("sysrst_pulse_e6",   int'(hist_pulse[6]), int'(5'b10000));
    release_all();
    check("sysrst_release_no_pulse", pulse_cnt, 1);

    check("pulse_onehot", onehot_bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
